// File: rtl/uart_pkg.sv
// Shared types and register-map constants for the memory-mapped UART transmitter.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_t;

    localparam logic [2:0] TXDATA_OFS = 3'h0;
    localparam logic [2:0] STATUS_OFS = 3'h4;

    localparam int unsigned ST_FULL    = 0;
    localparam int unsigned ST_EMPTY   = 1;
    localparam int unsigned ST_BUSY    = 2;
    localparam int unsigned ST_OVF     = 3;
    localparam int unsigned ST_CNT_LSB = 4;
    localparam int unsigned ST_CNT_MSB = 7;

    // STATUS only has a 4-bit count field; deeper FIFOs report 15.
    function automatic logic [3:0] sat_nibble(input logic [31:0] n);
        return (n > 32'd15) ? 4'hF : n[3:0];
    endfunction

endpackage

// File: rtl/uart_tx_periph_sync_fifo.sv
// Single-clock FIFO with simultaneous push/pop; a push into a full FIFO is
// only accepted when a pop frees the slot in the same cycle.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic                       o_drop,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;

    logic w_do_pop;
    logic w_do_push;

    assign o_full    = (r_count == AW'(0) + (AW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_drop    = i_push && !w_do_push;
    assign o_data    = r_mem[r_rd_ptr];
    assign o_count   = r_count;

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_periph.sv
// Memory-mapped 8N1 UART transmitter: TXDATA/STATUS register window feeding a
// byte FIFO that drains into a bit-serial engine driving tx.
module uart_tx_periph
    import uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'hFFFF_FF00,
    parameter int unsigned CLK_HZ     = 12_000_000,
    parameter int unsigned BAUD       = 115_200,
    parameter int unsigned DIVISOR    = CLK_HZ / BAUD,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dmem_wren,
    input  logic [31:0] dmem_address,
    input  logic [31:0] dmem_data_in,
    output logic [31:0] dmem_data_out,
    output logic        hit,
    output logic        tx
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned BW = $clog2(DIVISOR);
    localparam logic [BW-1:0] BAUD_RELOAD = BW'(DIVISOR - 1);

    // Register decode
    logic w_in_win;
    logic w_sel_status;
    logic w_wr_txdata;
    logic w_ovf_clr;
    logic w_unused;

    assign w_in_win     = (dmem_address[31:3] == BASE_ADDR[31:3]);
    assign w_sel_status = (dmem_address[2] == STATUS_OFS[2]);
    assign w_wr_txdata  = dmem_wren && w_in_win && (dmem_address[2] == TXDATA_OFS[2]);
    assign w_ovf_clr    = dmem_wren && w_in_win && w_sel_status && dmem_data_in[ST_OVF];
    assign w_unused     = ^{dmem_address[1:0], dmem_data_in[31:8]};

    // FIFO
    logic          w_pop;
    logic [7:0]    w_fifo_q;
    logic          w_full;
    logic          w_empty;
    logic          w_drop;
    logic [CW-1:0] w_count;

    sync_fifo #(
        .WIDTH(8),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (clk),
        .i_reset (reset),
        .i_push  (w_wr_txdata),
        .i_data  (dmem_data_in[7:0]),
        .i_pop   (w_pop),
        .o_data  (w_fifo_q),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_drop  (w_drop),
        .o_count (w_count)
    );

    // Serial engine state
    uart_state_t   r_state;
    uart_state_t   w_state_n;
    logic [7:0]    r_shreg;
    logic [7:0]    w_shreg_n;
    logic [BW-1:0] r_baud_cnt;
    logic [BW-1:0] w_baud_n;
    logic [2:0]    r_bit_idx;
    logic [2:0]    w_bit_n;
    logic          w_tx_n;
    logic          w_baud_done;
    logic          r_ovf;

    assign w_baud_done = (r_baud_cnt == '0);

    always_comb begin
        w_state_n = r_state;
        w_shreg_n = r_shreg;
        w_baud_n  = r_baud_cnt;
        w_bit_n   = r_bit_idx;
        w_pop     = 1'b0;

        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_pop     = 1'b1;
                    w_shreg_n = w_fifo_q;
                    w_baud_n  = BAUD_RELOAD;
                    w_bit_n   = '0;
                    w_state_n = START;
                end
            end
            START: begin
                if (w_baud_done) begin
                    w_baud_n  = BAUD_RELOAD;
                    w_state_n = DATA;
                end else begin
                    w_baud_n = r_baud_cnt - 1'b1;
                end
            end
            DATA: begin
                if (w_baud_done) begin
                    w_shreg_n = {1'b0, r_shreg[7:1]};
                    w_baud_n  = BAUD_RELOAD;
                    if (r_bit_idx == 3'd7) begin
                        w_state_n = STOP;
                    end else begin
                        w_bit_n = r_bit_idx + 1'b1;
                    end
                end else begin
                    w_baud_n = r_baud_cnt - 1'b1;
                end
            end
            STOP: begin
                if (w_baud_done) begin
                    w_baud_n = BAUD_RELOAD;
                    // Chain straight into the next start bit when more bytes wait.
                    if (!w_empty) begin
                        w_pop     = 1'b1;
                        w_shreg_n = w_fifo_q;
                        w_bit_n   = '0;
                        w_state_n = START;
                    end else begin
                        w_state_n = IDLE;
                    end
                end else begin
                    w_baud_n = r_baud_cnt - 1'b1;
                end
            end
            default: begin
                w_state_n = IDLE;
            end
        endcase

        // tx is registered from the next state so the pin changes on the same edge as the state.
        case (w_state_n)
            START:   w_tx_n = 1'b0;
            DATA:    w_tx_n = w_shreg_n[0];
            default: w_tx_n = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_shreg    <= '0;
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
            tx         <= 1'b1;
        end else begin
            r_state    <= w_state_n;
            r_shreg    <= w_shreg_n;
            r_baud_cnt <= w_baud_n;
            r_bit_idx  <= w_bit_n;
            tx         <= w_tx_n;
        end
    end

    // Overflow is sticky; a drop in the same cycle as a clear keeps it set.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end else if (w_ovf_clr) begin
            r_ovf <= 1'b0;
        end
    end

    // Read path
    logic [31:0] w_status;

    always_comb begin
        w_status                        = '0;
        w_status[ST_FULL]               = w_full;
        w_status[ST_EMPTY]              = w_empty;
        w_status[ST_BUSY]               = (r_state != IDLE);
        w_status[ST_OVF]                = r_ovf;
        w_status[ST_CNT_MSB:ST_CNT_LSB] = sat_nibble(32'(w_count));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hit           <= 1'b0;
            dmem_data_out <= '0;
        end else begin
            hit           <= w_in_win;
            dmem_data_out <= (w_in_win && w_sel_status) ? w_status : '0;
        end
    end

endmodule

// File: tb/tb_uart_tx_periph.sv
// Directed bench for uart_tx_periph with a frame-level reference model checked every cycle.
module tb_uart_tx_periph;

    localparam int unsigned DIV   = 4;
    localparam int unsigned DEPTH = 8;
    localparam int          FRAME = 10 * DIV;
    localparam logic [31:0] BASE  = 32'hFFFF_FF00;

    logic        clk;
    logic        reset;
    logic        dmem_wren;
    logic [31:0] dmem_address;
    logic [31:0] dmem_data_in;
    logic [31:0] dmem_data_out;
    logic        hit;
    logic        tx;

    int total = 0;
    int bad   = 0;
    bit chk_en = 0;

    uart_tx_periph #(
        .BASE_ADDR  (BASE),
        .DIVISOR    (DIV),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .dmem_wren     (dmem_wren),
        .dmem_address  (dmem_address),
        .dmem_data_in  (dmem_data_in),
        .dmem_data_out (dmem_data_out),
        .hit           (hit),
        .tx            (tx)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: byte queue plus a frame timer
    byte unsigned mq[$];
    bit           m_busy = 0;
    int           m_t = 0;
    logic [7:0]   m_cur = 0;
    bit           m_ovf = 0;
    logic         m_tx = 1;
    logic         m_hit = 0;
    logic [31:0]  m_dout = 0;

    longint       m_a;
    bit           m_win, m_pop, m_full, m_push, m_clr;
    int           m_n, m_b;
    logic [31:0]  m_st;

    always @(posedge clk) begin
        if (reset) begin
            mq.delete();
            m_busy = 0; m_t = 0; m_ovf = 0;
            m_tx = 1; m_hit = 0; m_dout = 0;
        end else begin
            m_a    = longint'(dmem_address);
            m_win  = (m_a >= longint'(BASE)) && (m_a <= longint'(BASE) + 7);
            m_n    = mq.size();
            m_full = (m_n == DEPTH);
            m_st   = 0;
            m_st[0] = m_full;
            m_st[1] = (m_n == 0);
            m_st[2] = m_busy;
            m_st[3] = m_ovf;
            m_st[7:4] = (m_n > 15) ? 4'hF : 4'(m_n);
            m_hit  = m_win;
            m_dout = (m_win && (m_a - longint'(BASE)) >= 4) ? m_st : 0;
            m_push = dmem_wren && m_win && (m_a - longint'(BASE)) < 4;
            m_clr  = dmem_wren && m_win && (m_a - longint'(BASE)) >= 4 && dmem_data_in[3];
            m_pop  = (m_n > 0) && (!m_busy || m_t == FRAME - 1);
            if (m_push && m_full && !m_pop) m_ovf = 1;
            else if (m_clr) m_ovf = 0;
            if (m_busy && m_t == FRAME - 1) begin
                if (m_pop) begin m_cur = mq.pop_front(); m_t = 0; end
                else m_busy = 0;
            end else if (m_busy) begin
                m_t++;
            end else if (m_pop) begin
                m_cur = mq.pop_front(); m_busy = 1; m_t = 0;
            end
            if (m_push && (!m_full || m_pop)) mq.push_back(dmem_data_in[7:0]);
            m_b  = m_t / DIV;
            m_tx = !m_busy ? 1'b1 : (m_b == 0) ? 1'b0 : (m_b <= 8) ? m_cur[m_b-1] : 1'b1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_tx",   {31'b0, tx},  {31'b0, m_tx});
            check("model_hit",  {31'b0, hit}, {31'b0, m_hit});
            check("model_dout", dmem_data_out, m_dout);
        end
    end

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        dmem_address = a; dmem_data_in = d; dmem_wren = 1;
        @(negedge clk);
        dmem_wren = 0;
    endtask

    task automatic wait_model(input int kind, input string name);
        int n = 0;
        while (n < 200 && !((kind == 0) ? (m_busy && m_t == FRAME - 1)
                                        : (m_busy && m_t / DIV == 4))) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            total++; bad++;
            $display("FAIL %s: timeout waiting for model condition", name);
        end
    endtask

    int exp1[10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
    int lows;

    initial begin
        reset = 1; dmem_wren = 0; dmem_address = 0; dmem_data_in = 0;
        repeat (2) @(negedge clk);
        chk_en = 1;
        reset = 0;
        check("rst_tx",   {31'b0, tx},  32'd1);
        check("rst_hit",  {31'b0, hit}, 32'd0);
        check("rst_dout", dmem_data_out, 32'd0);
        dmem_address = BASE + 4;
        @(negedge clk);
        check("rst_status", dmem_data_out, 32'h02);

        // 1: single byte 0xA5
        wr(BASE, 32'hA5);
        dmem_address = BASE + 4;
        @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            check("t1_bit", {31'b0, tx}, 32'(exp1[k]));
            if (k == 0) check("t1_status_prepop", dmem_data_out, 32'h10);
            else        check("t1_busy", {31'b0, dmem_data_out[2]}, 32'd1);
            repeat (DIV) @(negedge clk);
        end
        check("t1_status_stop", dmem_data_out, 32'h06);
        @(negedge clk);
        check("t1_status_idle", dmem_data_out, 32'h02);

        // 2: back-to-back 0x00, 0xFF
        dmem_address = BASE; dmem_data_in = 32'h00; dmem_wren = 1;
        @(negedge clk);
        dmem_data_in = 32'hFF;
        @(negedge clk);
        dmem_wren = 0;
        for (int i = 0; i < 80; i++) begin
            check("t2_line", {31'b0, tx}, ((i >= 36 && i < 40) || i >= 44) ? 32'd1 : 32'd0);
            @(negedge clk);
        end
        dmem_address = BASE + 4;
        @(negedge clk);
        check("t2_status_idle", dmem_data_out, 32'h02);

        // 3: overflow with 10 writes while the first frame is in flight
        for (int i = 0; i < 10; i++) begin
            dmem_address = BASE; dmem_data_in = 32'h10 + 32'(i); dmem_wren = 1;
            @(negedge clk);
        end
        dmem_wren = 0; dmem_address = BASE + 4;
        @(negedge clk);
        check("t3_status_ovf", dmem_data_out, 32'h8D);
        dmem_data_in = 32'h8; dmem_wren = 1;
        @(negedge clk);
        dmem_wren = 0;
        @(negedge clk);
        check("t3_status_clr", dmem_data_out, 32'h85);

        // 4: push on the exact cycle of a pop while full
        wait_model(0, "t4_wait");
        wr(BASE, 32'h55);
        dmem_address = BASE + 4;
        @(negedge clk);
        check("t4_status_full", dmem_data_out, 32'h85);

        // 5: reset during data bit 3
        wait_model(1, "t5_wait");
        reset = 1;
        @(negedge clk);
        reset = 0;
        check("t5_tx",   {31'b0, tx},  32'd1);
        check("t5_hit",  {31'b0, hit}, 32'd0);
        check("t5_dout", dmem_data_out, 32'd0);
        @(negedge clk);
        check("t5_status", dmem_data_out, 32'h02);
        check("t5_hit2",   {31'b0, hit}, 32'd1);
        lows = 0;
        for (int i = 0; i < 100; i++) begin
            if (tx !== 1'b1) lows++;
            @(negedge clk);
        end
        check("t5_quiet", 32'(lows), 32'd0);

        // 6: address decode
        wr(BASE + 8, 32'h33);
        check("t6_hit_hi", {31'b0, hit}, 32'd0);
        wr(BASE - 4, 32'h44);
        check("t6_hit_lo", {31'b0, hit}, 32'd0);
        dmem_address = BASE + 4;
        @(negedge clk);
        check("t6_status", dmem_data_out, 32'h02);
        check("t6_hit",    {31'b0, hit}, 32'd1);
        check("t6_tx",     {31'b0, tx},  32'd1);
        repeat (3) @(negedge clk);

        chk_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_periph.md
# uart_tx_periph

Memory-mapped UART transmitter that sits downstream of the RV32I core's data-memory port, beside the LED/RGB peripherals. Store instructions to its TXDATA register enqueue bytes into a small FIFO. A bit-serial engine drives the `tx` pin in 8N1 format. A STATUS register lets firmware poll for space, drain completion and dropped writes.

## Interface
- `BASE_ADDR`, 32'hFFFF_FF00: word-aligned base of the 2-register window.
- `CLK_HZ`, 12_000_000: system clock frequency.
- `BAUD`, 115_200: line rate. `DIVISOR = CLK_HZ / BAUD`, truncated; 104 at defaults. `DIVISOR` must be at least 2.
- `FIFO_DEPTH`, 8: power of two, at least 2.

Ports:
- `clk` input 1: system clock. Single clock domain.
- `reset` input 1: synchronous, active-high.
- `dmem_wren` input 1: store strobe from the core.
- `dmem_address` input 32: byte address of the access.
- `dmem_data_in` input 32: store data. Only bits [7:0] are used for TXDATA.
- `dmem_data_out` output 32: registered read data for this window.
- `hit` output 1: registered flag; `dmem_address` fell in this window last cycle. Upstream uses it to select `dmem_data_out`.
- `tx` output 1: serial line. Idles high.

## Operation
Register map:
- Offset 0x0, TXDATA:
  - Write: push `dmem_data_in[7:0]`.
  - Read: returns 0.
- Offset 0x4, STATUS, read:
  - bit0: full
  - bit1: empty
  - bit2: busy (FSM not IDLE)
  - bit3: overflow (sticky)
  - bits[7:4]: FIFO count, saturating at 15
  - all other bits: 0
- Offset 0x4, STATUS, write: writing 1 to bit3 clears overflow. All other bits are ignored.
- Addresses outside `[BASE_ADDR, BASE_ADDR+7]` produce no effect and leave `hit` low.

FIFO behaviour:
- A push while full is dropped and sets overflow, unless a pop occurs in the same cycle. Push with simultaneous pop when full is accepted; count is unchanged.
- Push with pop when empty cannot occur, because pop requires non-empty.

FSM states IDLE, START, DATA, STOP:
- **IDLE**: `tx`=1. If FIFO is non-empty, pop into `shreg`, load `baud_cnt = DIVISOR-1` and `bit_idx = 0`, then go to START.
- **START**: `tx`=0 for DIVISOR cycles, then go to DATA.
- **DATA**: `tx = shreg[0]`. Each time `baud_cnt` hits 0: shift right, then either increment `bit_idx` or, after bit 7, go to STOP. Transmission is LSB first.
- **STOP**: `tx`=1 for DIVISOR cycles. At the end, if FIFO is non-empty, pop and go directly to START with no idle gap. Otherwise go to IDLE.
- `baud_cnt` counts down from DIVISOR-1 to 0 and reloads on every state or bit transition.

## Timing
- Reset values: `tx`=1, `dmem_data_out`=0, `hit`=0, state IDLE, FIFO empty, overflow 0, all counters 0.
- Reset asserted mid-frame: `tx` returns to 1 on the next edge and queued bytes are discarded.
- Write accepted at edge E0.
- If IDLE, the pop occurs at E1 and `tx` falls after E1.
- A frame occupies exactly 10·DIVISOR cycles.
- Back-to-back bytes leave no idle cycles between a STOP and the next START.
- Read latency is one cycle: `dmem_data_out` and `hit` reflect the address presented at the prior edge.
- STATUS read in the same cycle as a push returns the pre-push count.
- Overflow set and clear in the same cycle: set wins.

## Structure
- `uart_pkg` holds:
  - the `uart_state_t` enum (IDLE/START/DATA/STOP)
  - register offsets `TXDATA_OFS`, `STATUS_OFS`
  - STATUS bit indices
- One sub-module, `sync_fifo`, parameterised by width and depth. It provides push/pop/full/empty/count with simultaneous push+pop support.
- Top-level integration:
  - The `memory` write path gates its own `dmem_wren` when `dmem_address` is in this window.
  - The read mux selects `dmem_data_out` when `hit` is set.
  - `tx` is mapped to a board pin.

## Test plan
Run the bench with `DIVISOR` overridden to 4 for speed.
1. **Single byte.** Write 0xA5 to TXDATA, then sample `tx` every 4 cycles. Expected: 0,1,0,1,0,0,1,0,1,1 (start, LSB-first data, stop). Busy is 1 during the frame and clears after 40 cycles.
2. **Back-to-back.** Write 0x00 then 0xFF in consecutive cycles. Expected: two frames totalling 80 cycles, with no high gap between the first stop bit and the second start bit.
3. **Overflow.** While the engine is stalled mid-frame, issue 10 writes. Expected: 8 queued plus 1 in the shifter, so 1 dropped. STATUS shows full=1, overflow=1, count=8. Writing 0x8 to STATUS then reads overflow=0.
4. **Full with simultaneous pop.** Write on the exact cycle of a pop with the FIFO full. Expected: the write is accepted, overflow stays 0, and count stays 8.
5. **Reset mid-frame.** Assert `reset` during DATA bit 3. Expected: the next cycle has `tx`=1, STATUS=0x2 (empty), and no further frame is sent.
6. **Address decode.** Write to BASE_ADDR+8 and to BASE_ADDR-4. Expected: no FIFO change and `hit` stays 0. A read of BASE_ADDR+4 returns STATUS one cycle later with `hit`=1.
